// File: rtl/m_stage_dm_pkg.sv
// mips_pkg: shared MIPS definitions for the memory stage.
// Holds the load/store opcode constants, the mem_op_t memory-operation
// enum, and a decoder from instruction opcode to mem_op_t.
package mips_pkg;

  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;

  typedef enum logic [3:0] {
    NONE, LW, LH, LHU, LB, LBU, SW, SH, SB
  } mem_op_t;

  function automatic mem_op_t decode_mem_op(input logic [5:0] opcode);
    mem_op_t op;
    case (opcode)
      OP_LW:   op = LW;
      OP_LH:   op = LH;
      OP_LHU:  op = LHU;
      OP_LB:   op = LB;
      OP_LBU:  op = LBU;
      OP_SW:   op = SW;
      OP_SH:   op = SH;
      OP_SB:   op = SB;
      default: op = NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/m_stage_dm_if.sv
// m_stage_dm_if: E->M pipeline bus of the memory stage.
//   flush            : load a bubble into the M register on the next edge
//   IR_E..BranchOP_E : E-stage values captured by the M register
//   fwd_*_W          : W-stage write-back, used to forward store data
//   IR_M..WD_M       : M-register copies, loaded data and effective store data
// master = upstream pipeline / bench side, slave = the memory stage.
interface m_stage_dm_if;
  logic        flush;
  logic [31:0] IR_E;
  logic [31:0] PC_E;
  logic [31:0] PC8_E;
  logic [31:0] AO_E;
  logic [31:0] RT_E;
  logic        BranchOP_E;
  logic        fwd_we_W;
  logic [4:0]  fwd_reg_W;
  logic [31:0] fwd_data_W;
  logic [31:0] IR_M;
  logic [31:0] PC_M;
  logic [31:0] PC8_M;
  logic [31:0] AO_M;
  logic        BranchOP_M;
  logic [31:0] DR_M;
  logic [31:0] WD_M;

  modport master (
    output flush, IR_E, PC_E, PC8_E, AO_E, RT_E, BranchOP_E,
    output fwd_we_W, fwd_reg_W, fwd_data_W,
    input  IR_M, PC_M, PC8_M, AO_M, BranchOP_M, DR_M, WD_M
  );

  modport slave (
    input  flush, IR_E, PC_E, PC8_E, AO_E, RT_E, BranchOP_E,
    input  fwd_we_W, fwd_reg_W, fwd_data_W,
    output IR_M, PC_M, PC8_M, AO_M, BranchOP_M, DR_M, WD_M
  );
endinterface

// File: rtl/m_stage_dm_ext.sv
// dm_ext: combinational load-data extractor.
//   word_i : full 32-bit memory word
//   addr_i : byte offset within the word (AO_M[1:0])
//   op_i   : memory operation
//   data_o : selected word/half/byte, sign- or zero-extended; 0 for non-loads
module dm_ext
  import mips_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  mem_op_t     op_i,
  output logic [31:0] data_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
  assign byte_sel = word_i[8*addr_i +: 8];

  always_comb begin
    data_o = 32'h0;
    case (op_i)
      LW:      data_o = word_i;
      LH:      data_o = {{16{half_sel[15]}}, half_sel};
      LHU:     data_o = {16'h0, half_sel};
      LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data_o = {24'h0, byte_sel};
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/m_stage_dm.sv
// m_stage_dm: MIPS memory stage.
// Holds the E->M pipeline register, the data memory (2^ADDR_WIDTH words),
// byte-lane store logic with W->M store-data forwarding, and the load
// extractor producing DR_M.
// Ports: clk, reset (synchronous, active-high), bus (m_stage_dm_if.slave).
// Parameters: ADDR_WIDTH (word-address bits), BASE_ADDR (byte address of word 0).
// Optional macro DM_DISPLAY_EN: log every committed store to the simulator.
module m_stage_dm
  import mips_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  m_stage_dm_if.slave   bus
);

  logic [31:0] ir_q, ir_d, pc_q, pc_d, pc8_q, pc8_d, ao_q, ao_d, rt_q, rt_d;
  logic        br_q, br_d;

  // A flushed stage is an all-zero bubble: IR 0 is sll $0 (nop).
  always_comb begin
    ir_d  = 32'h0;
    pc_d  = 32'h0;
    pc8_d = 32'h0;
    ao_d  = 32'h0;
    rt_d  = 32'h0;
    br_d  = 1'b0;
    if (!bus.flush) begin
      ir_d  = bus.IR_E;
      pc_d  = bus.PC_E;
      pc8_d = bus.PC8_E;
      ao_d  = bus.AO_E;
      rt_d  = bus.RT_E;
      br_d  = bus.BranchOP_E;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q  <= 32'h0;
      pc_q  <= 32'h0;
      pc8_q <= 32'h0;
      ao_q  <= 32'h0;
      rt_q  <= 32'h0;
      br_q  <= 1'b0;
    end else begin
      ir_q  <= ir_d;
      pc_q  <= pc_d;
      pc8_q <= pc8_d;
      ao_q  <= ao_d;
      rt_q  <= rt_d;
      br_q  <= br_d;
    end
  end

  mem_op_t mem_op;
  assign mem_op = decode_mem_op(ir_q[31:26]);

  // Store data: take the W result when W writes the rt register of this store,
  // so a store right behind a load never uses stale register data.
  logic        fwd_hit;
  logic [31:0] wd;
  assign fwd_hit = bus.fwd_we_W && (bus.fwd_reg_W != 5'd0) &&
                   (bus.fwd_reg_W == ir_q[20:16]);
  assign wd = fwd_hit ? bus.fwd_data_W : rt_q;

  // Word index; upper address bits beyond the array simply wrap.
  logic [31:0]           addr_off;
  logic [ADDR_WIDTH-1:0] idx;
  assign addr_off = ao_q - BASE_ADDR;
  assign idx      = addr_off[ADDR_WIDTH+1:2];

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rd_word;
  assign rd_word = mem_q[idx];

  logic [3:0]  be;
  logic [31:0] wdata;
  always_comb begin
    be    = 4'b0000;
    wdata = wd;
    case (mem_op)
      SW: begin
        be    = 4'b1111;
        wdata = wd;
      end
      SH: begin
        be    = ao_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd[15:0]}};
      end
      SB: begin
        be    = 4'b0001 << ao_q[1:0];
        wdata = {4{wd[7:0]}};
      end
      default: begin
        be    = 4'b0000;
        wdata = wd;
      end
    endcase
  end

  // Merge the selected lanes into the current word; others keep their value.
  logic [31:0] new_word;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign new_word[gi*8 +: 8] = be[gi] ? wdata[gi*8 +: 8] : rd_word[gi*8 +: 8];
    end
  endgenerate

  logic store_en;
  assign store_en = |be;

  // Reset clears every word and drops any store pending in M.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (store_en) begin
      mem_q[idx] <= new_word;
`ifdef DM_DISPLAY_EN
      $display("%d@%h: *%h <= %h", $time, pc_q, {ao_q[31:2], 2'b00}, new_word);
`endif
    end
  end

  logic [31:0] dr;
  dm_ext u_ext (
    .word_i (rd_word),
    .addr_i (ao_q[1:0]),
    .op_i   (mem_op),
    .data_o (dr)
  );

  assign bus.IR_M       = ir_q;
  assign bus.PC_M       = pc_q;
  assign bus.PC8_M      = pc8_q;
  assign bus.AO_M       = ao_q;
  assign bus.BranchOP_M = br_q;
  assign bus.DR_M       = dr;
  assign bus.WD_M       = wd;

endmodule

// File: tb/tb_m_stage_dm.sv
// tb_m_stage_dm: directed bench for m_stage_dm with an expected-value queue.
module tb_m_stage_dm;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pc = 32'h3000;

  always #5 clk = ~clk;

  m_stage_dm_if bus ();

  m_stage_dm #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd1, rt, 16'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] ao, input logic [31:0] rt);
    bus.IR_E       = ir;
    bus.AO_E       = ao;
    bus.RT_E       = rt;
    bus.PC_E       = pc;
    bus.PC8_E      = pc + 32'd8;
    bus.BranchOP_E = 1'b0;
    pc             = pc + 32'd4;
  endtask

  // Store enters M now; it commits at the following edge.
  task automatic store(input logic [5:0] op, input logic [4:0] rtr,
                       input logic [31:0] ao, input logic [31:0] data);
    drive(mk(op, rtr), ao, data);
    tick();
  endtask

  task automatic load(input string tag, input logic [5:0] op,
                      input logic [31:0] ao, input logic [31:0] exp);
    drive(mk(op, 5'd2), ao, 32'h0);
    exp_q.push_back(exp);
    tick();
    chk(tag, bus.DR_M, exp_q.pop_front());
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ir"},  bus.IR_M,  32'h0);
    chk({tag, "_pc"},  bus.PC_M,  32'h0);
    chk({tag, "_pc8"}, bus.PC8_M, 32'h0);
    chk({tag, "_ao"},  bus.AO_M,  32'h0);
    chk({tag, "_br"},  {31'h0, bus.BranchOP_M}, 32'h0);
    chk({tag, "_dr"},  bus.DR_M,  32'h0);
    chk({tag, "_wd"},  bus.WD_M,  32'h0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.flush      = 1'b0;
    bus.fwd_we_W   = 1'b0;
    bus.fwd_reg_W  = 5'd0;
    bus.fwd_data_W = 32'h0;
    drive(32'h0, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    chk_zero("por");

    // Fill low memory with all ones, then reset with a store pending in M.
    for (int a = 0; a < 32'h40; a += 4) store(OP_SW, 5'd3, a, 32'hFFFF_FFFF);
    load("fill_lw0", OP_LW, 32'h0, 32'hFFFF_FFFF);
    store(OP_SW, 5'd3, 32'h8, 32'h0);
    reset = 1'b1;
    drive(mk(OP_LW, 5'd2), 32'h4, 32'h55);
    bus.BranchOP_E = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("rst");
    load("rst_lw0", OP_LW, 32'h0, 32'h0);
    load("rst_lw8", OP_LW, 32'h8, 32'h0);

    // Pass-through registers.
    drive(32'h0, 32'h1, 32'h0);
    bus.BranchOP_E = 1'b1;
    tick();
    chk("br_pass", {31'h0, bus.BranchOP_M}, 32'h1);
    chk("pc8_pass", bus.PC8_M, bus.PC_M + 32'd8);
    bus.BranchOP_E = 1'b0;

    // Word round-trip, read right after the write.
    store(OP_SW, 5'd3, 32'h10, 32'h1234_5678);
    load("raw_lw", OP_LW, 32'h10, 32'h1234_5678);
    load("lw_lowbits", OP_LW, 32'h13, 32'h1234_5678);

    // Non-memory opcode returns zero even on a populated word.
    drive({6'h00, 26'h0}, 32'h10, 32'h0);
    tick();
    chk("nop_dr", bus.DR_M, 32'h0);

    // Partial stores and extension.
    store(OP_SB, 5'd3, 32'h23, 32'h0000_0080);
    store(OP_SH, 5'd3, 32'h20, 32'h0000_BEEF);
    load("part_lw",  OP_LW,  32'h20, 32'h8000_BEEF);
    load("part_lb",  OP_LB,  32'h23, 32'hFFFF_FF80);
    load("part_lbu", OP_LBU, 32'h23, 32'h0000_0080);
    load("part_lh",  OP_LH,  32'h20, 32'hFFFF_BEEF);
    load("part_lhu", OP_LHU, 32'h22, 32'h0000_8000);

    // Address wrap: 0x1014 aliases word 0x14.
    store(OP_SW, 5'd3, 32'h1014, 32'hA5A5_0F0F);
    load("wrap_lw", OP_LW, 32'h14, 32'hA5A5_0F0F);

    // Store-data forwarding from W.
    bus.fwd_we_W   = 1'b1;
    bus.fwd_reg_W  = 5'd8;
    bus.fwd_data_W = 32'hCAFE_0001;
    store(OP_SW, 5'd8, 32'h40, 32'h1);
    chk("fwd_wd", bus.WD_M, 32'hCAFE_0001);
    load("fwd_lw", OP_LW, 32'h40, 32'hCAFE_0001);
    bus.fwd_reg_W = 5'd0;
    store(OP_SW, 5'd0, 32'h44, 32'h1);
    chk("fwd0_wd", bus.WD_M, 32'h1);
    load("fwd0_lw", OP_LW, 32'h44, 32'h1);
    bus.fwd_we_W = 1'b0;
    bus.fwd_reg_W = 5'd8;
    store(OP_SW, 5'd8, 32'h48, 32'h77);
    chk("nofwd_wd", bus.WD_M, 32'h77);
    load("nofwd_lw", OP_LW, 32'h48, 32'h77);

    // Flush bubbles a store.
    bus.flush = 1'b1;
    store(OP_SW, 5'd3, 32'h50, 32'hAAAA_AAAA);
    bus.flush = 1'b0;
    chk("flush_ir", bus.IR_M, 32'h0);
    load("flush_lw", OP_LW, 32'h50, 32'h0);

    // Reset wins over flush; pending store discarded, memory cleared.
    store(OP_SW, 5'd3, 32'h60, 32'h5555_5555);
    reset     = 1'b1;
    bus.flush = 1'b1;
    drive(mk(OP_LW, 5'd2), 32'h10, 32'h0);
    tick();
    reset     = 1'b0;
    bus.flush = 1'b0;
    chk_zero("rstfl");
    load("rstfl_lw60", OP_LW, 32'h60, 32'h0);
    load("rstfl_lw10", OP_LW, 32'h10, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
